// File: rtl/reg_file_sb_pkg.sv
// Shared sizing constants for the integer register file and its pending-write scoreboard.
package reg_file_sb_pkg;

    localparam int unsigned REG_DBUS = 32;
    localparam int unsigned REG_ABUS = 5;
    localparam int unsigned REG_NUM  = 32;
    localparam int unsigned REG_CNTW = 2;

    localparam logic [REG_ABUS-1:0] ZERO_REG = '0;

    typedef logic [REG_DBUS-1:0] reg_data_t;
    typedef logic [REG_ABUS-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_sb_counter.sv
// Per-register pending-write counter: flush-clearing, saturating up/down, never underflows.
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             inc,
    input  logic             dec_req,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dec;

    always_comb begin
        // A writeback that finds nothing pending (e.g. after a flush) is ignored.
        dec   = dec_req && (cnt_q != '0);
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (inc && dec) begin
            cnt_d = cnt_q;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write integer register file with write-through bypass and a per-register
// pending-write scoreboard that stalls decode on source hazards or counter saturation.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int unsigned DATA_W   = REG_DBUS,
    parameter int unsigned ADDR_W   = REG_ABUS,
    parameter int unsigned NUM_REGS = REG_NUM,
    parameter int unsigned CNT_W    = REG_CNTW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   rd1_addr_i,
    input  logic [ADDR_W-1:0]   rd2_addr_i,
    input  logic                rd1_en_i,
    input  logic                rd2_en_i,
    output logic [DATA_W-1:0]   rd1_data_o,
    output logic [DATA_W-1:0]   rd2_data_o,
    input  logic                issue_en_i,
    input  logic [ADDR_W-1:0]   issue_addr_i,
    input  logic                wb_en_i,
    input  logic [ADDR_W-1:0]   wb_addr_i,
    input  logic [DATA_W-1:0]   wb_data_i,
    input  logic                flush_i,
    output logic                stall_o,
    output logic [NUM_REGS-1:0] busy_o
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [DATA_W-1:0]               regs_q [NUM_REGS];
    logic [NUM_REGS-1:0][CNT_W-1:0]  cnt;
    logic [NUM_REGS-1:0]             wb_hit;
    logic [NUM_REGS-1:0]             iss_hit;
    logic [NUM_REGS-1:0]             eff_nz;
    logic                            haz1;
    logic                            haz2;
    logic                            sat;
    logic                            iss;

    // Register array; x0 is never written and reads as zero below.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en_i && (wb_addr_i != ZERO_ADDR)) begin
            regs_q[wb_addr_i] <= wb_data_i;
        end
    end

    always_comb begin
        rd1_data_o = regs_q[rd1_addr_i];
        if (rd1_addr_i == ZERO_ADDR) begin
            rd1_data_o = '0;
        end else if (wb_en_i && (wb_addr_i == rd1_addr_i)) begin
            rd1_data_o = wb_data_i;
        end
    end

    always_comb begin
        rd2_data_o = regs_q[rd2_addr_i];
        if (rd2_addr_i == ZERO_ADDR) begin
            rd2_data_o = '0;
        end else if (wb_en_i && (wb_addr_i == rd2_addr_i)) begin
            rd2_data_o = wb_data_i;
        end
    end

    // eff_nz[r]: register r still has a producer in flight after this cycle's writeback.
    always_comb begin
        wb_hit = '0;
        eff_nz = '0;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            wb_hit[r] = wb_en_i && (wb_addr_i == ADDR_W'(r));
            eff_nz[r] = (cnt[r] != '0) && !(wb_hit[r] && (cnt[r] == CNT_W'(1)));
        end
    end

    always_comb begin
        haz1    = rd1_en_i && (rd1_addr_i != ZERO_ADDR) && eff_nz[rd1_addr_i];
        haz2    = rd2_en_i && (rd2_addr_i != ZERO_ADDR) && eff_nz[rd2_addr_i];
        sat     = issue_en_i && (issue_addr_i != ZERO_ADDR) && (cnt[issue_addr_i] == CNT_MAX)
                  && !wb_hit[issue_addr_i];
        stall_o = haz1 || haz2 || sat;
        iss     = issue_en_i && !stall_o && (issue_addr_i != ZERO_ADDR);
    end

    always_comb begin
        iss_hit = '0;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            iss_hit[r] = iss && (issue_addr_i == ADDR_W'(r));
        end
    end

    assign cnt[0] = '0;

    for (genvar r = 1; r < int'(NUM_REGS); r++) begin : g_cnt
        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush   (flush_i),
            .inc     (iss_hit[r]),
            .dec_req (wb_hit[r]),
            .cnt     (cnt[r])
        );
    end

    always_comb begin
        busy_o = '0;
        for (int r = 1; r < int'(NUM_REGS); r++) begin
            busy_o[r] = (cnt[r] != '0);
        end
    end

endmodule
